wb_check_reporter: RTL and testbench

WB_CHECK_REPORTER -- requirements
Module: wb_check_reporter

---
 rtl/wb_check_reporter.sv | 182 ++++++++++++++++++
 tb/tb_wb_check_reporter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_check_reporter.sv
// rtl/wb_check_reporter.sv - Wishbone check/compare reporter driving checkbits on io_out
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_cyc_i .. wbs_dat_i    Wishbone slave request (cycle, strobe, we, sel, adr, wdata)
//   wbs_ack_o, wbs_dat_o      Wishbone slave acknowledge and read data
//   io_out[15:0]              checkbits (routed to mprj_io[31:16] by the wrapper)
//   io_oeb[15:0]              output enables, active-low
//   irq_o                     one-cycle pulse on RUN->DONE
// Build option: define CHECK_IRQ_EN to enable the irq_o done pulse (tied 0 otherwise).

module wb_check_reporter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] REG_CHECK  = 3'd0;
  localparam logic [2:0] REG_EXPECT = 3'd1;
  localparam logic [2:0] REG_ACTUAL = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  state_t      state_q;
  logic [15:0] check_q;
  logic [15:0] expect_q;
  logic [7:0]  cmp_q;
  logic [7:0]  err_q;
  logic        ovf_q;
  logic        ack_q;
  logic [31:0] rdat_q;
  logic [15:0] io_out_q;
  logic [15:0] io_oeb_q;

  // Request captured when the hit is sampled; side effects use it on the ack cycle.
  logic [2:0]  req_reg_q;
  logic        req_we_q;
  logic [1:0]  req_sel_q;
  logic [15:0] req_dat_q;

  logic        hit_d;
  logic        pass_d;
  logic [31:0] status_d;
  logic [31:0] rdat_d;
  logic [15:0] io_out_d;
  logic        unused_bits;

  // Blocking the hit while ack is high gives one ack every two cycles on a held strobe.
  assign hit_d  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign pass_d = (err_q == 8'd0) && (cmp_q != 8'd0);

  // The 14-bit zero pad is cut to 12 bits so the fields fit one 32-bit word:
  // state[19:18], pass[17], ovf[16], err_cnt[15:8], cmp_cnt[7:0].
  assign status_d = {12'b0, state_q, pass_d, ovf_q, err_q, cmp_q};

  always_comb begin
    rdat_d = 32'h0;
    case (wbs_adr_i[4:2])
      REG_CHECK:  rdat_d = {16'h0, check_q};
      REG_EXPECT: rdat_d = {16'h0, expect_q};
      REG_STATUS: rdat_d = status_d;
      default:    rdat_d = 32'h0;
    endcase
  end

  always_comb begin
    io_out_d = check_q;
    case (state_q)
      ST_RUN:  io_out_d = 16'hAB60;
      ST_DONE: io_out_d = 16'hAB64 | {14'b0, pass_d, ovf_q};
      default: io_out_d = check_q;
    endcase
  end

  assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

`ifdef CHECK_IRQ_EN
  logic irq_q;
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      check_q   <= 16'h0;
      expect_q  <= 16'h0;
      cmp_q     <= 8'd0;
      err_q     <= 8'd0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdat_q    <= 32'h0;
      io_out_q  <= 16'h0;
      io_oeb_q  <= 16'hFFFF;
      req_reg_q <= 3'd0;
      req_we_q  <= 1'b0;
      req_sel_q <= 2'b00;
      req_dat_q <= 16'h0;
`ifdef CHECK_IRQ_EN
      irq_q     <= 1'b0;
`endif
    end else begin
      ack_q    <= hit_d;
      rdat_q   <= hit_d ? rdat_d : 32'h0;
      io_out_q <= io_out_d;
      io_oeb_q <= 16'h0000;
`ifdef CHECK_IRQ_EN
      irq_q    <= 1'b0;
`endif
      if (hit_d) begin
        req_reg_q <= wbs_adr_i[4:2];
        req_we_q  <= wbs_we_i;
        req_sel_q <= wbs_sel_i[1:0];
        req_dat_q <= wbs_dat_i[15:0];
      end

      if (ack_q && req_we_q) begin
        case (req_reg_q)
          REG_CHECK: begin
            if (req_sel_q[0]) check_q[7:0]  <= req_dat_q[7:0];
            if (req_sel_q[1]) check_q[15:8] <= req_dat_q[15:8];
          end
          REG_EXPECT: begin
            if (req_sel_q[0]) expect_q[7:0]  <= req_dat_q[7:0];
            if (req_sel_q[1]) expect_q[15:8] <= req_dat_q[15:8];
          end
          REG_ACTUAL: begin
            if (state_q == ST_RUN && req_sel_q == 2'b11) begin
              // A counter pinned at 255 flags overflow instead of wrapping.
              if (cmp_q == 8'hFF) ovf_q <= 1'b1;
              else                cmp_q <= cmp_q + 8'd1;
              if (req_dat_q != expect_q) begin
                if (err_q == 8'hFF) ovf_q <= 1'b1;
                else                err_q <= err_q + 8'd1;
              end
            end
          end
          REG_CTRL: begin
            // START has priority over FINISH in the same write.
            if (req_dat_q[0]) begin
              state_q <= ST_RUN;
              cmp_q   <= 8'd0;
              err_q   <= 8'd0;
              ovf_q   <= 1'b0;
            end else if (req_dat_q[1] && state_q == ST_RUN) begin
              state_q <= ST_DONE;
`ifdef CHECK_IRQ_EN
              irq_q   <= 1'b1;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign io_out    = io_out_q;
  assign io_oeb    = io_oeb_q;

endmodule

// File: tb/tb_wb_check_reporter.sv
// tb/tb_wb_check_reporter.sv - self-checking bench for wb_check_reporter

module tb_wb_check_reporter;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic        irq;

  int pass_cnt = 0;
  int total_cnt = 0;
  int irq_cnt = 0;

  // Reference model state
  int          m_state;
  logic [15:0] m_check;
  logic [15:0] m_expect;
  int          tot_cmp;
  int          tot_err;
  int          m_irq_exp = 0;

  wb_check_reporter #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (irq === 1'b1) irq_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = 0; m_check = 16'h0; m_expect = 16'h0; tot_cmp = 0; tot_err = 0;
  endtask

  task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    case (off[4:2])
      3'd0: begin
        if (s[0]) m_check[7:0] = d[7:0];
        if (s[1]) m_check[15:8] = d[15:8];
      end
      3'd1: begin
        if (s[0]) m_expect[7:0] = d[7:0];
        if (s[1]) m_expect[15:8] = d[15:8];
      end
      3'd2: if (m_state == 1 && s[1:0] == 2'b11) begin
        tot_cmp++;
        if (d[15:0] != m_expect) tot_err++;
      end
      3'd3: begin
        if (d[0]) begin
          m_state = 1; tot_cmp = 0; tot_err = 0;
        end else if (d[1] && m_state == 1) begin
          m_state = 2; m_irq_exp++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [7:0] m_cmp();
    return (tot_cmp > 255) ? 8'hFF : tot_cmp[7:0];
  endfunction
  function automatic logic [7:0] m_err();
    return (tot_err > 255) ? 8'hFF : tot_err[7:0];
  endfunction
  function automatic logic m_ovf();
    return (tot_cmp > 255) || (tot_err > 255);
  endfunction
  function automatic logic m_pass();
    return (tot_err == 0) && (tot_cmp != 0);
  endfunction
  function automatic logic [31:0] m_status();
    logic [1:0] st;
    st = m_state[1:0];
    return {12'b0, st, m_pass(), m_ovf(), m_err(), m_cmp()};
  endfunction
  function automatic logic [15:0] m_io();
    if (m_state == 1) return 16'hAB60;
    if (m_state == 2) return 16'hAB64 | {14'b0, m_pass(), m_ovf()};
    return m_check;
  endfunction

  // One Wishbone transfer, called at posedge+1; returns at posedge+1 after the ack cycle's edge.
  task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d,
                     input logic expect_ack, output logic [31:0] rd, output int lat);
    logic acked;
    acked = 1'b0; lat = 0; rd = 32'h0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    while (lat < 6 && !acked) begin
      @(posedge clk); #1;
      lat++;
      if (ack === 1'b1) begin acked = 1'b1; rd = rdat; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (acked !== expect_ack) $display("FAIL bus_ack adr=%h: got ack=%0b expected %0b", a, acked, expect_ack);
    else pass_cnt++;
  endtask

  task automatic do_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int lat;
    bus(BASE | {24'h0, off}, 1'b1, s, d, 1'b1, rd, lat);
    model_write(off, d, s);
  endtask

  task automatic do_read(input logic [7:0] off, output logic [31:0] rd);
    int lat;
    bus(BASE | {24'h0, off}, 1'b0, 4'hF, 32'h0, 1'b1, rd, lat);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; @(posedge clk); #1;
    rst = 1'b0; model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    int lat;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (io_oeb !== 16'hFFFF) $display("FAIL rst_oeb: got %h expected ffff", io_oeb); else pass_cnt++;
    total_cnt++; if (io_out !== 16'h0) $display("FAIL rst_io: got %h expected 0000", io_out); else pass_cnt++;
    total_cnt++; if ({ack, rdat, irq} !== 34'h0) $display("FAIL rst_bus: got ack=%b dat=%h irq=%b expected zeros", ack, rdat, irq); else pass_cnt++;
    rst = 1'b0; model_reset();
    @(posedge clk); #1;
    total_cnt++; if (io_oeb !== 16'h0000) $display("FAIL oeb_after_rst: got %h expected 0000", io_oeb); else pass_cnt++;
    bus(BASE | 32'h10, 1'b0, 4'hF, 32'h0, 1'b1, rd, lat);
    total_cnt++; if (lat !== 1) $display("FAIL ack_latency: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL status_after_rst: got %h expected 00000000", rd); else pass_cnt++;
    total_cnt++; if (io_out !== 16'h0) $display("FAIL io_after_rst: got %h expected 0000", io_out); else pass_cnt++;
  endtask

  task automatic test_check_write();
    logic [31:0] rd;
    do_write(8'h00, 32'h1234, 4'b0001);
    total_cnt++; if (io_out !== 16'h0000) $display("FAIL io_before_update: got %h expected 0000", io_out); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (io_out !== 16'h0034) $display("FAIL io_check: got %h expected 0034", io_out); else pass_cnt++;
    do_read(8'h00, rd);
    total_cnt++; if (rd !== 32'h0034) $display("FAIL check_lane0: got %h expected 00000034", rd); else pass_cnt++;
    do_write(8'h00, 32'hAB00, 4'b0010);
    do_read(8'h00, rd);
    total_cnt++; if (rd !== {16'h0, m_check}) $display("FAIL check_lane1: got %h expected %h", rd, {16'h0, m_check}); else pass_cnt++;
    do_write(8'h14, 32'hFFFF_FFFF, 4'hF);
    do_read(8'h14, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL unmapped_read: got %h expected 00000000", rd); else pass_cnt++;
    do_read(8'h1C, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL unmapped_read2: got %h expected 00000000", rd); else pass_cnt++;
    do_read(8'h00, rd);
    total_cnt++; if (rd !== 32'h0000AB34) $display("FAIL unmapped_write_effect: got %h expected 0000ab34", rd); else pass_cnt++;
  endtask

  task automatic test_pass_flow();
    logic [31:0] rd;
    int irq0;
    do_write(8'h0C, 32'h1, 4'hF);
    @(posedge clk); #1;
    total_cnt++; if (io_out !== 16'hAB60) $display("FAIL io_run: got %h expected ab60", io_out); else pass_cnt++;
    do_write(8'h04, 32'h5A5A, 4'hF);
    do_write(8'h08, 32'h5A5A, 4'hF);
    do_write(8'h08, 32'h5A5A, 4'hF);
    irq0 = irq_cnt;
    do_write(8'h0C, 32'h2, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (io_out !== 16'hAB66) $display("FAIL io_done_pass: got %h expected ab66", io_out); else pass_cnt++;
    do_read(8'h10, rd);
    total_cnt++; if (rd !== 32'h000A_0002) $display("FAIL status_pass: got %h expected 000a0002", rd); else pass_cnt++;
`ifdef CHECK_IRQ_EN
    total_cnt++; if (irq_cnt - irq0 !== 1) $display("FAIL irq_pulse: got %0d cycles expected 1", irq_cnt - irq0); else pass_cnt++;
`else
    total_cnt++; if (irq_cnt !== 0) $display("FAIL irq_tied: got %0d cycles expected 0", irq_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_fail_flow();
    logic [31:0] rd;
    do_write(8'h0C, 32'h1, 4'hF);
    do_write(8'h04, 32'h0001, 4'hF);
    do_write(8'h08, 32'h0002, 4'hF);
    do_write(8'h0C, 32'h2, 4'hF);
    @(posedge clk); #1;
    total_cnt++; if (io_out !== 16'hAB64) $display("FAIL io_done_fail: got %h expected ab64", io_out); else pass_cnt++;
    do_read(8'h10, rd);
    total_cnt++; if (rd[15:8] !== 8'd1 || rd !== m_status()) $display("FAIL status_fail: got %h expected %h", rd, m_status()); else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [31:0] rd;
    logic [15:0] v;
    v = 16'($urandom);
    do_write(8'h0C, 32'h1, 4'hF);
    do_write(8'h04, {16'h0, v}, 4'hF);
    for (int i = 0; i < 300; i++) do_write(8'h08, {16'($urandom), v}, 4'hF);
    do_write(8'h08, {16'h0, ~v}, 4'b0001);
    do_read(8'h10, rd);
    total_cnt++; if (rd[7:0] !== 8'hFF || rd[16] !== 1'b1 || rd !== m_status()) $display("FAIL saturate: got %h expected %h", rd, m_status()); else pass_cnt++;
    do_write(8'h0C, 32'h2, 4'hF);
    @(posedge clk); #1;
    total_cnt++; if (io_out !== 16'hAB67) $display("FAIL io_done_ovf: got %h expected ab67", io_out); else pass_cnt++;
  endtask

  task automatic test_ctrl_edges();
    logic [31:0] rd;
    do_write(8'h0C, 32'h2, 4'hF);
    do_write(8'h08, 32'h1, 4'hF);
    do_read(8'h10, rd);
    total_cnt++; if (rd !== m_status()) $display("FAIL finish_in_done: got %h expected %h", rd, m_status()); else pass_cnt++;
    pulse_reset();
    do_write(8'h0C, 32'h2, 4'hF);
    do_read(8'h10, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL finish_in_idle: got %h expected 00000000", rd); else pass_cnt++;
    do_write(8'h0C, 32'h1, 4'hF);
    do_write(8'h08, 32'h7, 4'hF);
    do_write(8'h08, 32'h0, 4'hF);
    do_write(8'h0C, 32'h3, 4'hF);
    do_read(8'h10, rd);
    total_cnt++; if (rd !== 32'h0004_0000) $display("FAIL start_wins: got %h expected 00040000", rd); else pass_cnt++;
  endtask

  task automatic test_held_strobe();
    logic [31:0] rd;
    logic [7:0] pat;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE | 32'h10; wdat = 32'h0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; pat[i] = ack; end
    cyc = 1'b0; stb = 1'b0; @(posedge clk); #1;
    total_cnt++; if (pat !== 8'b0101_0101) $display("FAIL held_read_acks: got %b expected 01010101", pat); else pass_cnt++;
    do_write(8'h04, 32'h00C3, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE | 32'h08; wdat = 32'h00C3;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; pat[i] = ack; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; @(posedge clk); #1;
    for (int i = 0; i < 4; i++) model_write(8'h08, 32'h00C3, 4'hF);
    do_read(8'h10, rd);
    total_cnt++; if (rd !== m_status()) $display("FAIL held_write_once: got %h expected %h", rd, m_status()); else pass_cnt++;
  endtask

  task automatic test_addr_miss();
    logic [31:0] rd;
    int lat;
    bus(BASE ^ 32'h0000_0100, 1'b1, 4'hF, 32'hBEEF, 1'b0, rd, lat);
    bus(BASE ^ 32'h8000_0000, 1'b0, 4'hF, 32'h0, 1'b0, rd, lat);
    do_read(8'h00, rd);
    total_cnt++; if (rd !== {16'h0, m_check}) $display("FAIL miss_no_write: got %h expected %h", rd, {16'h0, m_check}); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd;
    do_write(8'h00, 32'h9999, 4'hF);
    do_write(8'h0C, 32'h1, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE | 32'h0C; wdat = 32'h2;
    @(posedge clk); #1;
    total_cnt++; if (ack !== 1'b1) $display("FAIL midflight_ack: got %b expected 1", ack); else pass_cnt++;
    rst = 1'b1; #1;
    total_cnt++; if ({ack, io_out, io_oeb} !== {1'b0, 16'h0, 16'hFFFF}) $display("FAIL async_rst: got ack=%b io=%h oeb=%h expected 0 0000 ffff", ack, io_out, io_oeb); else pass_cnt++;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; model_reset();
    @(posedge clk); #1;
    do_read(8'h10, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL status_post_rst: got %h expected 00000000", rd); else pass_cnt++;
    total_cnt++; if (io_out !== 16'h0) $display("FAIL io_post_rst: got %h expected 0000", io_out); else pass_cnt++;
    do_write(8'h08, 32'h1, 4'hF);
    do_read(8'h10, rd);
    total_cnt++; if (rd !== 32'h0) $display("FAIL actual_in_idle: got %h expected 00000000", rd); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] d;
    logic [3:0] s;
    logic [3:0] sels [4];
    int n, kind;
    sels = '{4'hF, 4'h3, 4'h1, 4'h2};
    for (int r = 0; r < 5; r++) begin
      do_write(8'h0C, 32'h1, 4'hF);
      do_write(8'h04, $urandom, 4'hF);
      n = $urandom_range(8, 30);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 9);
        s = sels[$urandom_range(0, 3)];
        if (kind < 6) begin
          d = ($urandom_range(0, 1) == 1) ? {16'($urandom), m_expect} : $urandom;
          do_write(8'h08, d, s);
        end else if (kind < 8) begin
          do_write(8'h00, $urandom, s);
        end else begin
          do_write(8'h04, $urandom, s);
        end
      end
      if ($urandom_range(0, 1) == 1) do_write(8'h0C, 32'h2, 4'hF);
      do_read(8'h10, rd);
      total_cnt++; if (rd !== m_status()) $display("FAIL rand_status[%0d]: got %h expected %h", r, rd, m_status()); else pass_cnt++;
      do_read(8'h04, rd);
      total_cnt++; if (rd !== {16'h0, m_expect}) $display("FAIL rand_expect[%0d]: got %h expected %h", r, rd, {16'h0, m_expect}); else pass_cnt++;
      total_cnt++; if (io_out !== m_io()) $display("FAIL rand_io[%0d]: got %h expected %h", r, io_out, m_io()); else pass_cnt++;
    end
    repeat (2) @(posedge clk);
    #1;
`ifdef CHECK_IRQ_EN
    total_cnt++; if (irq_cnt !== m_irq_exp) $display("FAIL irq_total: got %0d expected %0d", irq_cnt, m_irq_exp); else pass_cnt++;
`else
    total_cnt++; if (irq_cnt !== 0) $display("FAIL irq_total: got %0d expected 0", irq_cnt); else pass_cnt++;
`endif
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    model_reset();
    test_reset();
    test_check_write();
    test_pass_flow();
    test_fail_flow();
    test_saturation();
    test_ctrl_edges();
    test_held_strobe();
    test_addr_miss();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
